// File: rtl/branch_resolve_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue_if
// Description : Bundle of the prediction, resolve and predictor-update
//               signals that connect fetch/execute to branch_resolve_queue.
//               master : fetch/execute side (drives pred_*, res_*)
//               slave  : the queue (drives pred_ready, upd_*, mispredict,
//                        count and, when MISPREDICT_COUNT_EN is defined,
//                        mp_count)
//               Parameter CW : width of the occupancy count.
//               Macro MISPREDICT_COUNT_EN adds the 16-bit mp_count signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_resolve_queue_if #(
    parameter int CW = 3
);
    logic          pred_valid;
    logic          pred_taken;
    logic          pred_ready;
    logic          res_valid;
    logic          res_taken;
    logic          upd_result;
    logic          upd_taken;
    logic          mispredict;
    logic [CW-1:0] count;
`ifdef MISPREDICT_COUNT_EN
    logic [15:0]   mp_count;
`endif

    modport master (
        output pred_valid,
        output pred_taken,
        output res_valid,
        output res_taken,
        input  pred_ready,
        input  upd_result,
        input  upd_taken,
        input  mispredict,
`ifdef MISPREDICT_COUNT_EN
        input  mp_count,
`endif
        input  count
    );

    modport slave (
        input  pred_valid,
        input  pred_taken,
        input  res_valid,
        input  res_taken,
        output pred_ready,
        output upd_result,
        output upd_taken,
        output mispredict,
`ifdef MISPREDICT_COUNT_EN
        output mp_count,
`endif
        output count
    );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_queue
// Description : Circular FIFO of predicted branch directions. Fetch pushes a
//               prediction, execute resolves the oldest one; the queue then
//               strobes the 2-bit predictor with the actual direction and
//               flags a mispredict, flushing all younger (wrong-path)
//               predictions on that same edge.
// Ports       : clk  - clock, all state on rising edge
//               rst  - synchronous active-high reset
//               bus  - branch_resolve_queue_if.slave
//                      pred_valid/pred_taken/pred_ready : prediction push
//                      res_valid/res_taken              : resolve of head
//                      upd_result/upd_taken/mispredict  : registered update
//                      count                            : valid entries
//                      mp_count (MISPREDICT_COUNT_EN)   : saturating total
// Config      : define MISPREDICT_COUNT_EN to build the mispredict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    branch_resolve_queue_if.slave bus
);

    localparam int            PW        = $clog2(DEPTH);
    localparam logic [CW-1:0] c_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] c_CNT_ONE = CW'(1);
    localparam logic [PW-1:0] c_PTR_ONE = PW'(1);

    logic [DEPTH-1:0] r_mem;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_upd_result;
    logic             r_upd_taken;
    logic             r_mispredict;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_head;
    logic             w_mp;

    // No pop-to-push bypass: readiness depends only on the registered count.
    assign w_ready = (r_count < c_DEPTH);
    assign w_push  = bus.pred_valid && w_ready;
    assign w_pop   = bus.res_valid && (r_count != '0);
    assign w_head  = r_mem[r_rd_ptr];
    assign w_mp    = w_pop && (bus.res_taken != w_head);

    // Pointers and occupancy. A mispredict empties the queue by snapping the
    // read pointer onto the write pointer; any push on that edge is
    // wrong-path and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mp) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset; stale entries sit outside [rd, wr).
    always_ff @(posedge clk) begin
        if (!rst && w_push && !w_mp) begin
            r_mem[r_wr_ptr] <= bus.pred_taken;
        end
    end

    // One-cycle registered predictor update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_upd_result <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            r_upd_result <= w_pop;
            r_upd_taken  <= w_pop && bus.res_taken;
            r_mispredict <= w_mp;
        end
    end

`ifdef MISPREDICT_COUNT_EN
    logic [15:0] r_mp_count;

    // Counts on the same edge that registers mispredict high; saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mp_count <= '0;
        end else if (w_mp && (r_mp_count != 16'hFFFF)) begin
            r_mp_count <= r_mp_count + 16'd1;
        end
    end

    assign bus.mp_count = r_mp_count;
`endif

    assign bus.pred_ready = w_ready;
    assign bus.upd_result = r_upd_result;
    assign bus.upd_taken  = r_upd_taken;
    assign bus.mispredict = r_mispredict;
    assign bus.count      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_queue
// Description : Self-checking bench for branch_resolve_queue (DEPTH=4).
//               A reference FIFO model predicts each cycle's outputs; the
//               expected update is pushed to a scoreboard when stimulus is
//               driven and popped/compared after the clock edge.
//               Macro MISPREDICT_COUNT_EN also enables mp_count checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_resolve_queue_if #(.CW(CW)) bif ();

    branch_resolve_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        logic upd;
        logic tk;
        logic mp;
    } exp_t;

    exp_t sb[$];
    bit   mq[$];
    int   mpc = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, model, scoreboard, then compare.
    task automatic step(input logic r, input logic pv, input logic pt,
                        input logic rv, input logic rt);
        exp_t e;
        exp_t got;
        bit   ready;
        bit   push;
        bit   pop;
        bit   mp;
        rst            = r;
        bif.pred_valid = pv;
        bif.pred_taken = pt;
        bif.res_valid  = rv;
        bif.res_taken  = rt;
        #1;
        ready = (mq.size() < DEPTH);
        if (!r) begin
            chk("pred_ready", {31'd0, bif.pred_ready}, {31'd0, ready});
        end
        if (r) begin
            mq.delete();
            mpc = 0;
            e   = '{upd: 1'b0, tk: 1'b0, mp: 1'b0};
        end else begin
            push = pv && ready;
            pop  = rv && (mq.size() != 0);
            mp   = pop && (rt != mq[0]);
            e    = '{upd: pop, tk: pop && rt, mp: mp};
            if (mp) begin
                mq.delete();
                if (mpc < 16'hFFFF) mpc++;
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back(pt);
            end
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("upd_result", {31'd0, bif.upd_result}, {31'd0, got.upd});
        chk("upd_taken",  {31'd0, bif.upd_taken},  {31'd0, got.tk});
        chk("mispredict", {31'd0, bif.mispredict}, {31'd0, got.mp});
        chk("count", 32'(bif.count), 32'(mq.size()));
`ifdef MISPREDICT_COUNT_EN
        chk("mp_count", 32'(bif.mp_count), 32'(mpc));
`endif
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        rst            = 1'b1;
        bif.pred_valid = 1'b0;
        bif.pred_taken = 1'b0;
        bif.res_valid  = 1'b0;
        bif.res_taken  = 1'b0;

        // Basic push T,N,T then resolve taken (matches head).
        do_reset();
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Fill, overflow drop, push+resolve while full.
        do_reset();
        repeat (4) step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Mispredict flush with simultaneous wrong-path push.
        do_reset();
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // Resolve with empty queue.
        do_reset();
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);

        // Ten push/resolve pairs, pointers wrap.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 1'($urandom_range(0, 1)), 0, 0);
            step(0, 0, 0, 1, 1'($urandom_range(0, 1)));
        end

        // Three mispredicts, then reset mid-stream with two entries.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
